// File: rtl/ram_alu_sequencer.sv
// Command sequencer: mem[dst] = mem[a] OP mem[b] over a single RAM port and an external ALU.
// All outputs are registered; each FSM state drives its RAM/ALU outputs during its own cycle.
module ram_alu_sequencer #(
  parameter int MEM_DEPTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [7:0]       cmd_addr_a,
  input  logic [7:0]       cmd_addr_b,
  input  logic [7:0]       cmd_addr_d,
  output logic [7:0]       ram_addr,
  output logic [15:0]      ram_d,
  output logic             ram_we,
  input  logic [15:0]      ram_q,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic             alu_op,
  input  logic [15:0]      alu_rout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      result,
  output logic [CNT_W-1:0] cmd_count,
  output logic [2:0]       dbg_state
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and command inputs are ignored until IDLE returns.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERR    = 3'd1,
    RD_A   = 3'd2,
    RD_B   = 3'd3,
    EXEC   = 3'd4,
    WR_SET = 3'd5,
    WR_PUL = 3'd6,
    WR_HLD = 3'd7
  } state_t;

  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

  state_t            state, state_nxt;
  logic              op_r;
  logic [7:0]        b_r, d_r;
  logic [15:0]       rega;
  logic              accept, bad_addr;
  logic              nxt_we, nxt_done, nxt_err, nxt_alu_op;
  logic [7:0]        nxt_addr;
  logic [15:0]       nxt_d, nxt_alu_a, nxt_alu_b, nxt_result;
  logic [CNT_W-1:0]  nxt_count;

  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign bad_addr  = ({1'b0, cmd_addr_a} >= DEPTH) || ({1'b0, cmd_addr_b} >= DEPTH) ||
                     ({1'b0, cmd_addr_d} >= DEPTH);
  assign dbg_state = state;

  // Next-state logic also computes the values every output register takes for that state.
  always_comb begin
    state_nxt  = state;
    nxt_addr   = ram_addr;
    nxt_d      = ram_d;
    nxt_alu_a  = alu_a;
    nxt_alu_b  = alu_b;
    nxt_alu_op = alu_op;
    nxt_result = result;
    nxt_count  = cmd_count;
    nxt_we     = 1'b0;
    nxt_done   = 1'b0;
    nxt_err    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_addr) begin
            state_nxt = ERR;
            nxt_err   = 1'b1;
          end else begin
            state_nxt = RD_A;
            nxt_addr  = cmd_addr_a;
          end
        end
      end
      ERR:  state_nxt = IDLE;
      RD_A: begin
        state_nxt = RD_B;
        nxt_addr  = b_r;
      end
      RD_B: begin
        // alu_b doubles as regb: it captures the B operand at the end of RD_B.
        state_nxt  = EXEC;
        nxt_alu_a  = rega;
        nxt_alu_b  = ram_q;
        nxt_alu_op = op_r;
      end
      EXEC: begin
        // ram_d doubles as regr so the write data is stable from the setup cycle on.
        state_nxt = WR_SET;
        nxt_addr  = d_r;
        nxt_d     = alu_rout;
      end
      WR_SET: begin
        state_nxt = WR_PUL;
        nxt_we    = 1'b1;
      end
      WR_PUL: begin
        state_nxt  = WR_HLD;
        nxt_done   = 1'b1;
        nxt_result = ram_d;
        nxt_count  = cmd_count + CNT_W'(1);
      end
      WR_HLD:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= 1'b0;
      b_r       <= 8'h00;
      d_r       <= 8'h00;
      rega      <= 16'h0000;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 8'h00;
      ram_d     <= 16'h0000;
      alu_a     <= 16'h0000;
      alu_b     <= 16'h0000;
      alu_op    <= 1'b0;
      result    <= 16'h0000;
      cmd_count <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      done      <= nxt_done;
      err       <= nxt_err;
      ram_we    <= nxt_we;
      ram_addr  <= nxt_addr;
      ram_d     <= nxt_d;
      alu_a     <= nxt_alu_a;
      alu_b     <= nxt_alu_b;
      alu_op    <= nxt_alu_op;
      result    <= nxt_result;
      cmd_count <= nxt_count;
      if (accept) begin
        op_r <= cmd_op;
        b_r  <= cmd_addr_b;
        d_r  <= cmd_addr_d;
      end
      if (state == RD_A) rega <= ram_q;
    end
  end

endmodule

// File: tb/tb_ram_alu_sequencer.sv
// Bench for ram_alu_sequencer: behavioural RAM/ALU models, table-driven commands,
// hand-written back-to-back, counter-wrap and mid-operation reset sequences.
module tb_ram_alu_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_op = 1'b0;
  logic [7:0]       cmd_addr_a = 8'h00, cmd_addr_b = 8'h00, cmd_addr_d = 8'h00;
  logic [7:0]       ram_addr;
  logic [15:0]      ram_d, ram_q;
  logic             ram_we;
  logic [15:0]      alu_a, alu_b, alu_rout;
  logic             alu_op;
  logic             busy, done, err;
  logic [15:0]      result;
  logic [CNT_W-1:0] cmd_count;
  logic [2:0]       dbg_state;

  ram_alu_sequencer #(.MEM_DEPTH(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_d(cmd_addr_d),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rout(alu_rout),
    .busy(busy), .done(done), .err(err), .result(result), .cmd_count(cmd_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM and ALU models
  logic [15:0] mem [0:255];
  int          we_edges = 0;
  logic [7:0]  we_addr;
  logic [15:0] we_d;
  assign ram_q    = ram_we ? 16'h0000 : mem[ram_addr];
  assign alu_rout = alu_op ? (alu_a + alu_b) : (alu_a | alu_b);
  always @(posedge ram_we) begin
    mem[ram_addr] = ram_d;
    we_addr = ram_addr;
    we_d    = ram_d;
    we_edges++;
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {31'b0, cmd_ready | busy | done | err | ram_we | alu_op}, 32'h0);
    check({name, "_addr"}, {24'h0, ram_addr}, 32'h0);
    check({name, "_d"}, {16'h0, ram_d}, 32'h0);
    check({name, "_alu"}, {alu_a, alu_b}, 32'h0);
    check({name, "_result"}, {16'h0, result}, 32'h0);
    check({name, "_count"}, {28'h0, cmd_count}, 32'h0);
  endtask

  // waits from cycle 1 after accept until done or err; lat = cycle index where seen
  task automatic wait_end(output int lat);
    lat = 1;
    while (!(done || err) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // driver: present a command, wait for its accept, scramble inputs, wait for completion
  task automatic run_cmd(input bit op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d, output int lat);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_addr_a = a; cmd_addr_b = b; cmd_addr_d = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = ~op;
    cmd_addr_a = 8'hEE; cmd_addr_b = 8'hEE; cmd_addr_d = 8'h1F;
    wait_end(lat);
  endtask

  typedef struct {
    bit          op;
    logic [7:0]  a, b, d;
    logic [15:0] va, vb, exp_r;
    bit          bad;
  } vec_t;

  vec_t vecs[9];
  int   lat, edges0, k;
  logic [15:0] res0;

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no end expected end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vecs[0] = '{1'b1, 8'd1,  8'd2,  8'd3,   16'h0003, 16'h0005, 16'h0008, 1'b0};
    vecs[1] = '{1'b0, 8'd4,  8'd5,  8'd4,   16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0};
    vecs[2] = '{1'b1, 8'd6,  8'd7,  8'd8,   16'hFFFF, 16'h0002, 16'h0001, 1'b0};
    vecs[3] = '{1'b1, 8'd40, 8'd1,  8'd2,   16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 8'd9,  8'd9,  8'd10,  16'h1234, 16'h1234, 16'h2468, 1'b0};
    vecs[5] = '{1'b1, 8'd31, 8'd0,  8'd31,  16'h8000, 16'h8001, 16'h0001, 1'b0};
    vecs[6] = '{1'b0, 8'd1,  8'd32, 8'd2,   16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 8'd1,  8'd2,  8'd255, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[8] = '{1'b1, 8'd10, 8'd11, 8'd12,  16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    #1 check("ready_before_edge", {31'b0, cmd_ready}, 32'h0);
    @(negedge clk);
    check("ready_after_edge", {31'b0, cmd_ready}, 32'h1);
    check("busy_idle", {31'b0, busy}, 32'h0);

    // table-driven commands
    foreach (vecs[i]) begin
      mem[vecs[i].a] = vecs[i].va;
      mem[vecs[i].b] = vecs[i].vb;
      edges0 = we_edges;
      res0   = result;
      if (!vecs[i].bad) exp_q.push_back(vecs[i].exp_r);
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, lat);
      if (vecs[i].bad) begin
        check($sformatf("v%0d_err", i), {31'b0, err}, 32'h1);
        check($sformatf("v%0d_err_lat", i), lat, 32'd1);
        check($sformatf("v%0d_result_held", i), {16'h0, result}, {16'h0, res0});
      end else begin
        exp_cnt++;
        exp_v = exp_q.pop_front();
        check($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
        check($sformatf("v%0d_done_lat", i), lat, 32'd6);
        check($sformatf("v%0d_result", i), {16'h0, result}, {16'h0, exp_v});
        check($sformatf("v%0d_mem", i), {16'h0, mem[vecs[i].d]}, {16'h0, exp_v});
        check($sformatf("v%0d_we_addr", i), {24'h0, we_addr}, {24'h0, vecs[i].d});
        check($sformatf("v%0d_we_d", i), {16'h0, we_d}, {16'h0, exp_v});
        check($sformatf("v%0d_hold", i), {8'h0, ram_addr, ram_d}, {8'h0, vecs[i].d, exp_v});
        check($sformatf("v%0d_alu_op_held", i), {31'b0, alu_op}, {31'b0, vecs[i].op});
      end
      check($sformatf("v%0d_we_edges", i), we_edges - edges0, vecs[i].bad ? 32'd0 : 32'd1);
      check($sformatf("v%0d_count", i), {28'h0, cmd_count}, exp_cnt % 16);
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {30'b0, done, err}, 32'h0);
      check($sformatf("v%0d_idle", i), {30'b0, cmd_ready, busy}, 32'h2);
    end

    // back-to-back with cmd_valid held high; second command reads the first's result
    mem[13] = 16'h0001; mem[14] = 16'h0002;
    cmd_valid = 1'b1; cmd_op = 1'b1;
    cmd_addr_a = 8'd13; cmd_addr_b = 8'd14; cmd_addr_d = 8'd15;
    check("b2b_ready", {31'b0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_addr_a = 8'd15; cmd_addr_b = 8'd13; cmd_addr_d = 8'd16;
    k = 1;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b_gap", k, 32'd7);
    check("b2b_first_mem", {16'h0, mem[15]}, 32'h0003);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_end(lat);
    exp_cnt += 2;
    check("b2b_second_lat", lat, 32'd6);
    check("b2b_second_mem", {16'h0, mem[16]}, 32'h0004);
    check("b2b_count", {28'h0, cmd_count}, exp_cnt % 16);

    // counter wrap through 2^CNT_W
    mem[20] = 16'h0011; mem[21] = 16'h0100;
    for (int i = 0; i < 9; i++) begin
      run_cmd(1'b0, 8'd20, 8'd21, 8'd22, lat);
      exp_cnt++;
      check($sformatf("wrap%0d_count", i), {28'h0, cmd_count}, exp_cnt % 16);
    end
    check("wrap_mem", {16'h0, mem[22]}, 32'h0111);

    // reset during RD_B abandons the command without a write
    mem[23] = 16'hABCD;
    edges0 = we_edges;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    cmd_addr_a = 8'd1; cmd_addr_b = 8'd2; cmd_addr_d = 8'd23;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_rel_ready0", {31'b0, cmd_ready}, 32'h0);
    @(negedge clk);
    check("rst_rel_ready1", {31'b0, cmd_ready}, 32'h1);
    check("rst_no_write", {16'h0, mem[23]}, 32'hABCD);
    check("rst_no_we", we_edges - edges0, 32'd0);
    exp_cnt = 0;

    // first command after reset
    mem[24] = 16'h0100; mem[25] = 16'h0023;
    run_cmd(1'b1, 8'd24, 8'd25, 8'd26, lat);
    exp_cnt++;
    check("post_rst_lat", lat, 32'd6);
    check("post_rst_mem", {16'h0, mem[26]}, 32'h0123);
    check("post_rst_count", {28'h0, cmd_count}, exp_cnt % 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
